// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bi, one bit per clock, LSB first.
// Operands load on start; D/Bo/V/Z are held until the next completion or reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic             bit_a, bit_b, bit_d, br_nx;
    logic [WIDTH-1:0] res_shift;

    // One full-subtractor cell; the borrow flop closes the loop across cycles.
    always_comb begin
        bit_a     = op_a_q[0];
        bit_b     = op_b_q[0];
        bit_d     = bit_a ^ bit_b ^ br_q;
        br_nx     = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        res_shift = {bit_d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bo_d    = bo_q;
        v_d     = v_q;
        z_d     = z_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d  = A;
                    op_b_d  = B;
                    br_d    = Bi;
                    cnt_d   = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                res_d  = res_shift;
                br_d   = br_nx;
                cnt_d  = cnt_q + CW'(1);
                // Last bit: publish the result in the same edge it is formed.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = res_shift;
                    bo_d    = br_nx;
                    v_d     = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
                    z_d     = (res_shift == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign D    = d_q;
    assign Bo   = bo_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, held-start handshake,
// mid-operation reset and random operands against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bi;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bo;
    logic         V;
    logic         Z;

    int checks;
    int errors;

    logic [W-1:0] prev_d;
    logic         prev_bo, prev_v, prev_z;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bi    (Bi),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo),
        .V     (V),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^W; V from the captured sign bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] ed, output logic ebo, output logic ev,
                         output logic ez);
        int diff;
        diff = int'(a) - int'(b) - int'(bi);
        ed   = W'(diff);
        ebo  = (int'(a) < int'(b) + int'(bi));
        ev   = (a[W-1] ^ b[W-1]) & (ed[W-1] ^ a[W-1]);
        ez   = (ed == '0);
    endtask

    // Issue one operation at the next edge and follow it cycle by cycle.
    // hold=1 keeps start asserted throughout to show it is ignored outside IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input bit hold);
        logic [W-1:0] ed;
        logic         ebo, ev, ez;
        model(a, b, bi, ed, ebo, ev, ez);
        A = a; B = b; Bi = bi; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("done_after_accept", done, 1'b0);
        for (int k = 1; k < W; k++) begin
            A  = W'($urandom);
            B  = W'($urandom);
            Bi = 1'($urandom);
            @(posedge clk); #1;
            check("busy_shift", busy, 1'b1);
            check("done_shift", done, 1'b0);
            check("d_hold_shift", D, prev_d);
            check("flags_hold_shift", {Bo, V, Z}, {prev_bo, prev_v, prev_z});
        end
        @(posedge clk); #1;
        check("done_pulse", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("d_result", D, ed);
        check("bo_result", Bo, ebo);
        check("v_result", V, ev);
        check("z_result", Z, ez);
        $display("op A=%02h B=%02h Bi=%0d -> D=%02h Bo=%0d V=%0d Z=%0d (exp %02h %0d %0d %0d)",
                 a, b, bi, D, Bo, V, Z, ed, ebo, ev, ez);
        prev_d = ed; prev_bo = ebo; prev_v = ev; prev_z = ez;
        @(posedge clk); #1;
        check("done_single_cycle", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("d_hold_idle", D, prev_d);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_d = '0; prev_bo = 1'b0; prev_v = 1'b0; prev_z = 1'b0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bi = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_d", D, '0);
        check("rst_flags", {Bo, V, Z}, 3'b000);
        rst = 1'b0;

        repeat (2) begin
            @(posedge clk); #1;
            check("idle_no_start_busy", busy, 1'b0);
            check("idle_no_start_done", done, 1'b0);
        end

        run_op(8'h5A, 8'h23, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, 1'b0);
        run_op(8'h33, 8'h33, 1'b1, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0);

        // Back-to-back with start held high: one issue every W+2 cycles.
        for (int i = 0; i < 4; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        check("no_extra_done", done, 1'b0);

        // Reset at the fourth shift edge aborts the operation.
        A = 8'hC3; B = 8'h12; Bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_d", D, '0);
        check("abort_flags", {Bo, V, Z}, 3'b000);
        $display("reset mid-operation: busy=%0d done=%0d D=%02h", busy, done, D);
        prev_d = '0; prev_bo = 1'b0; prev_v = 1'b0; prev_z = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 1'b0);
            check("abort_d_stays", D, '0);
        end

        run_op(8'h05, 8'h07, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                check("gap_done", done, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes D = A − B − Bi, one bit per clock, LSB first, using a single registered borrow stage.
- It is the subtracting counterpart of the team's gate-level ripple full adder. The arithmetic datapath uses it where area matters more than latency.
- Operands are loaded in parallel on a start handshake. The result is presented in parallel, with borrow, signed-overflow and zero flags, and is held until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on an accepted start.
- B  input  WIDTH  subtrahend; captured on an accepted start.
- Bi  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while the serial computation is in progress.
- done  output  1  single-cycle pulse when the result registers update.
- D  output  WIDTH  difference, registered.
- Bo  output  1  final borrow-out (unsigned A < B + Bi), registered.
- V  output  1  signed overflow of A − B − Bi, registered.
- Z  output  1  high when D == 0, registered.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-high on rst.
  - While rst is high at an edge: state → IDLE; busy=0, done=0, D=0, Bo=0, V=0, Z=0; internal shift registers, borrow flop and bit counter are cleared.
  - rst during SHIFT aborts the operation; no done pulse is produced and no result is published.
- State machine IDLE / SHIFT / DONE:
  - IDLE with start=1 at edge 0: capture A, B, Bi into operand shift registers and the borrow flop; counter=0; → SHIFT; busy=1 from edge 0.
  - IDLE with start=0: remain in IDLE.
  - SHIFT, edges 1..WIDTH, one bit per edge:
    - a=opA[0], b=opB[0], br=borrow flop.
    - d = a ^ b ^ br.
    - br_next = (~a & b) | (~(a ^ b) & br).
    - d shifts into the MSB of the result shift register; opA and opB shift right; counter increments.
  - At edge WIDTH (counter reaches WIDTH−1 before that edge), in the same edge:
    - D ← result shift register including the final bit; Bo ← br_next.
    - V ← (A[WIDTH−1] ^ B[WIDTH−1]) & (D[WIDTH−1] ^ A[WIDTH−1]), using the captured operand MSBs.
    - Z ← (D == 0).
    - → DONE; busy=0, done=1.
  - DONE: at the next edge → IDLE; done=0.
- Start acceptance:
  - start is ignored in SHIFT and DONE; a held start is accepted on the first IDLE edge. Minimum issue interval is therefore WIDTH+2 cycles.
  - A, B and Bi may change freely after the accepting edge; the captured copies are used.
- Latency:
  - start accepted at edge 0 → done high in the cycle following edge WIDTH, for exactly one cycle.
  - Total latency is WIDTH cycles to valid results.
- Output hold:
  - D, Bo, V and Z hold the previous result through IDLE and SHIFT; they change only at the completion edge or on reset.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Bo is the unsigned borrow; V is the signed overflow; the two are independent.
  - Bi=1 with A=B gives D = all-ones and Bo=1.

Test Plan:
- Basic subtraction (WIDTH=8): rst 2 cycles; start with A=0x5A, B=0x23, Bi=0 → busy high 8 cycles, done pulse 1 cycle after edge 8, D=0x37, Bo=0, V=0, Z=0.
- Unsigned underflow: A=0x00, B=0x01, Bi=0 → D=0xFF, Bo=1, V=0, Z=0.
- Signed overflow: A=0x80, B=0x01, Bi=0 → D=0x7F, Bo=0, V=1.
- Borrow-in and zero result: A=0x10, B=0x0F, Bi=1 → D=0x00, Z=1, Bo=0, V=0. Then A=0x33, B=0x33, Bi=1 → D=0xFF, Bo=1, Z=0.
- Handshake rules:
  - Hold start high continuously with changing A/B → each operation uses the values present at its accepting IDLE edge.
  - Operations issue every 10 cycles.
  - No extra done pulses; D is unchanged between done pulses.
- Reset mid-operation: assert rst at edge 4 of SHIFT → next cycle busy=0, done=0, D=0, flags=0. A new start after reset gives a correct result: A=0x05, B=0x07 → D=0xFE, Bo=1.
